sym_dn_lut_rank_pipe: RTL and testbench

//  Parametrised symmetric decision-node (DN) LUT read stage for the IB layered LDPC partial VNU.

---
 rtl/sym_dn_lut_rank_pipe_if.sv | 29 ++
 rtl/sym_dn_lut_rank_pipe.sv | 114 +++++++++++
 tb/tb_sym_dn_lut_rank_pipe.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sym_dn_lut_rank_pipe_if.sv
// sym_dn_lut_rank_pipe_if: read-port and LUT-load signal bundle for the DN LUT read stage
interface sym_dn_lut_rank_pipe_if #(
    parameter int QUAN_SIZE = 3,
    parameter int PORT_NUM  = 2,
    parameter int WR_W      = 4
);
    logic [PORT_NUM-1:0]           in_valid;
    logic [PORT_NUM-1:0]           transpose_en;
    logic [PORT_NUM*QUAN_SIZE-1:0] y0_in;
    logic [PORT_NUM*QUAN_SIZE-1:0] y1_in;
    logic [PORT_NUM-1:0]           out_valid;
    logic [PORT_NUM-1:0]           t_c;
    logic                          lut_load_start;
    logic                          lut_wr_valid;
    logic [WR_W-1:0]               lut_wr_data;
    logic                          lut_wr_ready;
    logic                          lut_load_done;
    logic                          active_bank;

    modport master (
        output in_valid, transpose_en, y0_in, y1_in, lut_load_start, lut_wr_valid, lut_wr_data,
        input  out_valid, t_c, lut_wr_ready, lut_load_done, active_bank
    );

    modport slave (
        input  in_valid, transpose_en, y0_in, y1_in, lut_load_start, lut_wr_valid, lut_wr_data,
        output out_valid, t_c, lut_wr_ready, lut_load_done, active_bank
    );
endinterface

// File: rtl/sym_dn_lut_rank_pipe.sv
// sym_dn_lut_rank_pipe: symmetric DN LUT read stage, PORT_NUM 3-cycle read pipes over a double-buffered LUT
module sym_dn_lut_rank_pipe #(
    parameter int QUAN_SIZE = 3,
    parameter int PORT_NUM  = 2,
    parameter int WR_W      = 4
) (
    input logic                read_clk,
    input logic                rst,
    sym_dn_lut_rank_pipe_if.slave bus
);
    localparam int Q     = QUAN_SIZE;
    localparam int AW    = 2 * Q - 1;
    localparam int DEPTH = 1 << AW;
    localparam int BEATS = DEPTH / WR_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    if (DEPTH % WR_W != 0) begin : g_bad_wr_w
        $error("sym_dn_lut_rank_pipe: 2**AW must be a multiple of WR_W");
    end

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

    state_t              state, state_d;
    logic [CW-1:0]       cnt, cnt_d;
    logic                act;
    logic                we;
    logic [AW-1:0]       wbase;
    logic [DEPTH-1:0]    bank [2];
    logic [AW-1:0]       addr   [PORT_NUM];
    logic [AW-1:0]       addr_q [PORT_NUM];
    logic [PORT_NUM-1:0] sgn, sgn_q, sgn_q2;
    logic [PORT_NUM-1:0] vld_q, vld_q2, bit_q, ov_q, tc_q;

    // Fold: a negative y0 is mirrored, and y1 is mirrored whenever the overall sign flips
    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            sgn[i]  = bus.y0_in[i*Q+Q-1] ^ bus.transpose_en[i];
            addr[i] = {bus.y0_in[i*Q +: Q-1] ^ {(Q-1){bus.y0_in[i*Q+Q-1]}},
                       (bus.y0_in[i*Q+Q-1] ^ bus.transpose_en[i]) ? ~bus.y1_in[i*Q +: Q]
                                                                   : bus.y1_in[i*Q +: Q]};
        end
    end

    always_ff @(posedge read_clk) begin
        if (rst) begin
            vld_q  <= '0;
            vld_q2 <= '0;
            sgn_q  <= '0;
            sgn_q2 <= '0;
            bit_q  <= '0;
            ov_q   <= '0;
            tc_q   <= '0;
            for (int i = 0; i < PORT_NUM; i++) addr_q[i] <= '0;
        end else begin
            vld_q  <= bus.in_valid;
            sgn_q  <= sgn;
            for (int i = 0; i < PORT_NUM; i++) begin
                addr_q[i] <= addr[i];
                bit_q[i]  <= bank[act][addr_q[i]];
            end
            vld_q2 <= vld_q;
            sgn_q2 <= sgn_q;
            ov_q   <= vld_q2;
            tc_q   <= (vld_q2 & (bit_q ^ sgn_q2)) | (~vld_q2 & tc_q);
        end
    end

    assign wbase = AW'(cnt * WR_W);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        we      = 1'b0;
        case (state)
            IDLE: begin
                state_d = bus.lut_load_start ? LOAD : IDLE;
                cnt_d   = '0;
            end
            LOAD: begin
                if (bus.lut_load_start) begin
                    cnt_d = '0;
                end else if (bus.lut_wr_valid) begin
                    we      = 1'b1;
                    cnt_d   = (cnt == LAST) ? '0 : cnt + 1'b1;
                    state_d = (cnt == LAST) ? COMMIT : LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Writes only ever target the shadow bank, so reads always see a complete table
    always_ff @(posedge read_clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            act     <= 1'b0;
            bank[0] <= '0;
            bank[1] <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (state == COMMIT) act <= ~act;
            if (we) bank[~act][wbase +: WR_W] <= bus.lut_wr_data;
        end
    end

    assign bus.out_valid     = ov_q;
    assign bus.t_c           = tc_q;
    assign bus.lut_wr_ready  = (state == LOAD);
    assign bus.lut_load_done = (state == COMMIT);
    assign bus.active_bank   = act;
endmodule

// File: tb/tb_sym_dn_lut_rank_pipe.sv
// tb_sym_dn_lut_rank_pipe: directed and random checks of the DN LUT read stage against a table model
module tb_sym_dn_lut_rank_pipe;
    localparam int Q  = 3;
    localparam int P  = 2;
    localparam int W  = 4;
    localparam int AW = 2 * Q - 1;
    localparam int D  = 1 << AW;
    localparam int NB = D / W;
    localparam int PQ = P * Q;
    localparam logic [P-1:0] ALL = '1;

    logic read_clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   d0;

    always #5 read_clk = ~read_clk;

    sym_dn_lut_rank_pipe_if #(.QUAN_SIZE(Q), .PORT_NUM(P), .WR_W(W)) bus ();

    sym_dn_lut_rank_pipe #(.QUAN_SIZE(Q), .PORT_NUM(P), .WR_W(W)) dut (
        .read_clk (read_clk),
        .rst      (rst),
        .bus      (bus.slave)
    );

    // Table model: two banks of plain ints, reads resolved from the folded address
    int m_bank [2][D];
    int m_act, m_st, m_cnt;
    int cap_v [P], cap_a [P], cap_s [P];
    int lk_v [P], lk_b [P], lk_s [P];
    logic [P-1:0] e_ov, e_tc;

    function automatic int msb(int y);
        return (y >> (Q - 1)) & 1;
    endfunction

    function automatic int mirror(int y);
        return (1 << Q) - 1 - y;
    endfunction

    function automatic int lut_addr(int y0, int y1, int te);
        int s = msb(y0) ^ te;
        return (msb(y0) != 0 ? mirror(y0) : y0) * (1 << Q) + (s != 0 ? mirror(y1) : y1);
    endfunction

    always @(posedge read_clk) begin
        if (rst) begin
            foreach (m_bank[b, a]) m_bank[b][a] = 0;
            m_act = 0;
            m_st  = 0;
            m_cnt = 0;
            e_ov  = '0;
            e_tc  = '0;
            for (int p = 0; p < P; p++) begin
                cap_v[p] = 0;
                lk_v[p]  = 0;
            end
        end else begin
            for (int p = 0; p < P; p++) begin
                int y0, y1, te;
                e_ov[p] = (lk_v[p] != 0);
                if (lk_v[p] != 0) e_tc[p] = ((lk_b[p] ^ lk_s[p]) != 0);
                lk_v[p] = cap_v[p];
                lk_s[p] = cap_s[p];
                lk_b[p] = m_bank[m_act][cap_a[p]];
                y0 = int'(bus.y0_in[p*Q +: Q]);
                y1 = int'(bus.y1_in[p*Q +: Q]);
                te = int'(bus.transpose_en[p]);
                cap_v[p] = int'(bus.in_valid[p]);
                cap_s[p] = msb(y0) ^ te;
                cap_a[p] = lut_addr(y0, y1, te);
            end
            if (m_st == 0) begin
                if (bus.lut_load_start) begin
                    m_st  = 1;
                    m_cnt = 0;
                end
            end else if (m_st == 1) begin
                if (bus.lut_load_start) begin
                    m_cnt = 0;
                end else if (bus.lut_wr_valid) begin
                    for (int i = 0; i < W; i++) m_bank[1-m_act][m_cnt*W+i] = int'(bus.lut_wr_data[i]);
                    if (m_cnt == NB - 1) m_st = 2;
                    else m_cnt++;
                end
            end else begin
                m_act = 1 - m_act;
                m_st  = 0;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    always @(negedge read_clk) begin
        if (chk_en) begin
            check("out_valid", 32'(bus.out_valid), 32'(e_ov));
            check("t_c", 32'(bus.t_c), 32'(e_tc));
            check("active_bank", 32'(bus.active_bank), m_act);
            check("lut_wr_ready", 32'(bus.lut_wr_ready), 32'(m_st == 1));
            check("lut_load_done", 32'(bus.lut_load_done), 32'(m_st == 2));
            if (bus.lut_load_done) done_cnt++;
        end
    end

    task automatic rand_reads(input bit all_valid);
        bus.in_valid     = all_valid ? ALL : P'($urandom);
        bus.transpose_en = P'($urandom);
        bus.y0_in        = PQ'($urandom);
        bus.y1_in        = PQ'($urandom);
    endtask

    task automatic reset_dut;
        rst = 1'b1;
        repeat (2) @(negedge read_clk);
        rst = 1'b0;
    endtask

    task automatic do_read(input logic [P-1:0] te, input logic [PQ-1:0] y0, input logic [PQ-1:0] y1,
                           input logic [P-1:0] want, input string nm);
        bus.in_valid     = ALL;
        bus.transpose_en = te;
        bus.y0_in        = y0;
        bus.y1_in        = y1;
        @(negedge read_clk);
        bus.in_valid = '0;
        @(negedge read_clk);
        check({nm, "_early"}, 32'(bus.out_valid), 0);
        @(negedge read_clk);
        check({nm, "_ov"}, 32'(bus.out_valid), 32'(ALL));
        check({nm, "_tc"}, 32'(bus.t_c), 32'(want));
        @(negedge read_clk);
        check({nm, "_ov_drop"}, 32'(bus.out_valid), 0);
        check({nm, "_hold"}, 32'(bus.t_c), 32'(want));
    endtask

    task automatic load(input logic [D-1:0] word, input bit gaps, input string nm);
        bus.lut_load_start = 1'b1;
        @(negedge read_clk);
        bus.lut_load_start = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (gaps && (k == 3 || k == 6)) begin
                bus.lut_wr_valid = 1'b0;
                @(negedge read_clk);
            end
            bus.lut_wr_valid = 1'b1;
            bus.lut_wr_data  = word[k*W +: W];
            @(negedge read_clk);
        end
        bus.lut_wr_valid = 1'b0;
        check({nm, "_done"}, 32'(bus.lut_load_done), 1);
        @(negedge read_clk);
        check({nm, "_done_end"}, 32'(bus.lut_load_done), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid       = '0;
        bus.transpose_en   = '0;
        bus.y0_in          = '0;
        bus.y1_in          = '0;
        bus.lut_load_start = 1'b0;
        bus.lut_wr_valid   = 1'b0;
        bus.lut_wr_data    = '0;

        // T1: reset state and a zero-LUT read with s=0 on both ports
        reset_dut;
        chk_en = 1'b1;
        check("t1_active", 32'(bus.active_bank), 0);
        check("t1_ov", 32'(bus.out_valid), 0);
        check("t1_tc", 32'(bus.t_c), 0);
        check("t1_ready", 32'(bus.lut_wr_ready), 0);
        check("t1_done", 32'(bus.lut_load_done), 0);
        do_read(2'b00, {3'b010, 3'b010}, {3'b011, 3'b011}, 2'b00, "t1_read");

        // T2: entry[a]=a[0]
        load({(D/4){4'hA}}, 1'b0, "t2_load");
        check("t2_active", 32'(bus.active_bank), 1);
        do_read(2'b00, {3'b011, 3'b001}, {3'b111, 3'b010}, 2'b10, "t2_r1");
        do_read(2'b10, {3'b110, 3'b101}, {3'b000, 3'b010}, 2'b00, "t2_r2");
        do_read(2'b01, {3'b111, 3'b101}, {3'b000, 3'b010}, 2'b00, "t2_r3");
        do_read(2'b11, {3'b000, 3'b101}, {3'b001, 3'b101}, 2'b11, "t2_r4");

        // T3: all-ones load with gaps under back-to-back reads
        reset_dut;
        d0 = done_cnt;
        fork
            load({D{1'b1}}, 1'b1, "t3_load");
            repeat (NB + 10) begin
                rand_reads(1'b1);
                @(negedge read_clk);
            end
        join
        bus.in_valid = '0;
        repeat (4) @(negedge read_clk);
        check("t3_done_once", done_cnt - d0, 1);
        check("t3_active", 32'(bus.active_bank), 1);
        do_read(2'b00, {3'b011, 3'b001}, {3'b111, 3'b010}, 2'b11, "t3_read");

        // T4: IDLE ignores beats, restart after beat 3 needs 8 more beats
        bus.lut_wr_valid = 1'b1;
        bus.lut_wr_data  = 4'hF;
        repeat (3) begin
            @(negedge read_clk);
            check("t4_idle_ready", 32'(bus.lut_wr_ready), 0);
        end
        bus.lut_wr_valid   = 1'b0;
        bus.lut_load_start = 1'b1;
        @(negedge read_clk);
        bus.lut_load_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.lut_wr_valid = 1'b1;
            bus.lut_wr_data  = 4'(k + 1);
            @(negedge read_clk);
        end
        bus.lut_load_start = 1'b1;
        bus.lut_wr_data    = 4'hF;
        @(negedge read_clk);
        bus.lut_load_start = 1'b0;
        for (int k = 0; k < NB; k++) begin
            bus.lut_wr_data = 4'h5;
            @(negedge read_clk);
            check("t4_restart_done", 32'(bus.lut_load_done), 32'(k == NB - 1));
        end
        bus.lut_wr_valid = 1'b0;
        @(negedge read_clk);
        check("t4_active", 32'(bus.active_bank), 0);
        do_read(2'b00, {3'b011, 3'b001}, {3'b111, 3'b010}, 2'b01, "t4_read");

        // T5: reset at beat 5 while active_bank=1 and reads are in flight
        load(D'(32'h3C96_5AE1), 1'b0, "t5_pre");
        for (int c = 0; c < 6; c++) begin
            rand_reads(1'b1);
            bus.lut_load_start = (c == 0);
            bus.lut_wr_valid   = (c != 0);
            bus.lut_wr_data    = W'($urandom);
            @(negedge read_clk);
        end
        rst = 1'b1;
        @(negedge read_clk);
        check("t5_ov", 32'(bus.out_valid), 0);
        check("t5_active", 32'(bus.active_bank), 0);
        check("t5_ready", 32'(bus.lut_wr_ready), 0);
        bus.in_valid     = '0;
        bus.lut_wr_valid = 1'b0;
        @(negedge read_clk);
        rst = 1'b0;
        do_read(2'b00, {3'b010, 3'b010}, {3'b011, 3'b011}, 2'b00, "t5_read");

        // T6: random reads and loads against the model
        for (int c = 0; c < 3000; c++) begin
            rand_reads(1'b0);
            bus.lut_load_start = ($urandom_range(0, 39) == 0);
            bus.lut_wr_valid   = 1'($urandom);
            bus.lut_wr_data    = W'($urandom);
            @(negedge read_clk);
        end
        bus.in_valid       = '0;
        bus.lut_load_start = 1'b0;
        bus.lut_wr_valid   = 1'b0;
        repeat (5) @(negedge read_clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
